// File: rtl/tx_fifo_pkg.sv
// Shared types and widths for the TX FIFO drain path.
// Holds the byte width, the byte-counter width and the drain FSM encoding.
package tx_fifo_pkg;

  localparam int W_DATA     = 8;
  localparam int BYTE_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    PRESENT = 3'd3,
    GAP     = 3'd4
  } state_e;

endpackage

// File: rtl/tx_fifo_drain_ctrl.sv
// Drains a BRAM-backed TX FIFO into a UART valid/ready port: 3 cycles per byte, a forced
// idle gap after every BURST_MAX bytes; i_tx_ready low holds the byte and stops further reads.
module tx_fifo_drain_ctrl
  import tx_fifo_pkg::*;
#(
  parameter int W_DATA     = tx_fifo_pkg::W_DATA,
  parameter int BURST_MAX  = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  i_RCLK,
  input  logic                  i_rrstn,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  input  logic [W_DATA-1:0]     i_fifo_rdata,
  output logic                  o_fifo_rd_en,
  output logic [W_DATA-1:0]     o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic [BYTE_CNT_W-1:0] o_byte_cnt
);

  localparam logic [7:0]            BURST_LIM = 8'(BURST_MAX);
  localparam logic [7:0]            GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [BYTE_CNT_W-1:0] CNT_ONE   = 1;

  state_e                  state_q, state_d;
  logic                    run_q;
  logic [7:0]              burst_q, burst_d;
  logic [7:0]              gap_q, gap_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [W_DATA-1:0]       tx_data_q, tx_data_d;
  logic                    rd_en_q, tx_valid_q, busy_q;
  logic                    can_read, accept;

  // run_q delays the effect of reset release by one edge so the first read
  // cannot start on the very edge that follows release.
  assign can_read = run_q & i_enable & ~i_fifo_empty;
  assign accept   = tx_valid_q & i_tx_ready;

  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    gap_d      = gap_q;
    byte_cnt_d = byte_cnt_q;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE: begin
        if (can_read) state_d = RD_REQ;
      end
      RD_REQ: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        tx_data_d = i_fifo_rdata;
        state_d   = PRESENT;
      end
      PRESENT: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + CNT_ONE;
          burst_d    = burst_q + 8'd1;
          if (burst_q + 8'd1 == BURST_LIM) begin
            state_d = GAP;
            gap_d   = 8'd0;
          end else if (can_read) begin
            state_d = RD_REQ;
          end else begin
            state_d = IDLE;
            burst_d = 8'd0;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          gap_d   = 8'd0;
          burst_d = 8'd0;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_RCLK or negedge i_rrstn) begin
    if (!i_rrstn) begin
      run_q      <= 1'b0;
      state_q    <= IDLE;
      burst_q    <= 8'd0;
      gap_q      <= 8'd0;
      byte_cnt_q <= '0;
      tx_data_q  <= '0;
      rd_en_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      state_q    <= state_d;
      burst_q    <= burst_d;
      gap_q      <= gap_d;
      byte_cnt_q <= byte_cnt_d;
      tx_data_q  <= tx_data_d;
      rd_en_q    <= (state_d == RD_REQ);
      tx_valid_q <= (state_d == PRESENT);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign o_fifo_rd_en = rd_en_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_valid   = tx_valid_q;
  assign o_busy       = busy_q;
  assign o_byte_cnt   = byte_cnt_q;

endmodule
